// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one-cycle-latency word reads and
// buffers returned instructions in a 2-entry queue so decode can stall safely.
module fetch_stage #(
   parameter int                AWIDTH   = 32,
   parameter int                DWIDTH   = 32,
   parameter logic [AWIDTH-1:0] BASEADDR = 32'h0100_0000
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req_o,
   output logic [AWIDTH-1:0] imem_addr_o,
   input  logic [DWIDTH-1:0] imem_rdata_i,
   input  logic              redirect_i,
   input  logic [AWIDTH-1:0] redirect_pc_i,
   input  logic              stall_i,
   output logic              valid_o,
   output logic [AWIDTH-1:0] pc_o,
   output logic [DWIDTH-1:0] insn_o
);

   localparam logic [DWIDTH-1:0] NOP = DWIDTH'(32'h0000_0013);

   logic [AWIDTH-1:0] pc_q;
   logic              inflight_q;
   logic [AWIDTH-1:0] inflight_pc_q;
   logic [1:0]        count_q;
   logic              rd_ptr_q;
   logic              wr_ptr_q;
   logic [AWIDTH-1:0] fifo_pc   [2];
   logic [DWIDTH-1:0] fifo_insn [2];

   logic              pop;
   logic              push;
   logic              issue;
   logic [2:0]        occ;
   logic [AWIDTH-1:0] target;

   always_comb begin
      valid_o = (count_q != 2'd0);
      pop     = valid_o && !stall_i;
      push    = inflight_q && !redirect_i;
      occ     = {1'b0, count_q} + {2'b00, inflight_q};
      target  = {redirect_pc_i[AWIDTH-1:2], 2'b00};
      // Outputs are gated by rst so they show reset values while it is held low.
      issue   = rst && (redirect_i || ((occ - {2'b00, pop}) < 3'd2));
      imem_req_o  = issue;
      imem_addr_o = (rst && redirect_i) ? target : pc_q;
      pc_o        = valid_o ? fifo_pc[rd_ptr_q]   : pc_q;
      insn_o      = valid_o ? fifo_insn[rd_ptr_q] : NOP;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q       <= BASEADDR;
         inflight_q <= 1'b0;
         count_q    <= 2'd0;
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
      end else begin
         inflight_q <= issue;
         if (issue)
            pc_q <= imem_addr_o + AWIDTH'(4);
         if (redirect_i) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
         end else begin
            count_q  <= count_q + 2'(push) - 2'(pop);
            rd_ptr_q <= rd_ptr_q ^ pop;
            wr_ptr_q <= wr_ptr_q ^ push;
         end
      end
   end

   // Queue payload and in-flight PC carry no reset; count/inflight qualify them.
   always_ff @(posedge clk) begin
      if (issue)
         inflight_pc_q <= imem_addr_o;
      if (push) begin
         fifo_pc[wr_ptr_q]   <= inflight_pc_q;
         fifo_insn[wr_ptr_q] <= imem_rdata_i;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stall, redirect, PC wrap and
// asynchronous reset, with a one-cycle-latency memory model.
module tb_fetch_stage;

   localparam logic [31:0] B   = 32'h0100_0000;
   localparam logic [31:0] T   = 32'h0100_0200;
   localparam logic [31:0] R2  = 32'h0200_0010;
   localparam logic [31:0] K   = 32'h5A5A_5A5A;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'h0;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        valid;
   logic [31:0] pc;
   logic [31:0] insn;

   int n_total = 0;
   int n_pass  = 0;

   fetch_stage #(.AWIDTH(32), .DWIDTH(32), .BASEADDR(B)) dut (
      .clk          (clk),
      .rst          (rst),
      .imem_req_o   (imem_req),
      .imem_addr_o  (imem_addr),
      .imem_rdata_i (imem_rdata),
      .redirect_i   (redirect),
      .redirect_pc_i(redirect_pc),
      .stall_i      (stall),
      .valid_o      (valid),
      .pc_o         (pc),
      .insn_o       (insn)
   );

   always #5 clk = ~clk;

   // Memory returns the address scrambled by K so pc/insn mix-ups are visible.
   always @(posedge clk)
      if (imem_req) imem_rdata <= imem_addr ^ K;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic out(input string tag, input logic [31:0] epc);
      check({tag, " valid"}, {31'd0, valid}, 32'd1);
      check({tag, " pc"}, pc, epc);
      check({tag, " insn"}, insn, epc ^ K);
   endtask

   task automatic req(input string tag, input logic r, input logic [31:0] a);
      check({tag, " req"}, {31'd0, imem_req}, {31'd0, r});
      check({tag, " addr"}, imem_addr, a);
   endtask

   task automatic empty(input string tag);
      check({tag, " valid"}, {31'd0, valid}, 32'd0);
   endtask

   task automatic reset_vals(input string tag);
      req(tag, 1'b0, B);
      empty(tag);
      check({tag, " pc"}, pc, B);
      check({tag, " insn"}, insn, NOP);
   endtask

   initial begin
      rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      repeat (2) @(posedge clk);
      #3;
      reset_vals("rst");

      // Fill and stream
      nxt(); rst = 1'b1; #2;
      req("c0", 1'b1, B); empty("c0");
      nxt(); #2; req("c1", 1'b1, B + 4); empty("c1");
      nxt(); #2; out("c2", B);
      nxt(); #2; out("c3", B + 4);
      nxt(); #2; out("c4", B + 8);

      // Stall for 5 cycles: head held, requests stop
      nxt(); stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) nxt();
         #2;
         out("stall", B + 12);
         req("stall", 1'b0, B + 20);
      end
      nxt(); stall = 1'b0; #2; out("rel0", B + 12); req("rel0", 1'b1, B + 20);
      nxt(); #2; out("rel1", B + 16);
      nxt(); #2; out("rel2", B + 20);
      nxt(); #2; out("rel3", B + 24);

      // Redirect while streaming, misaligned target
      nxt(); redirect = 1'b1; redirect_pc = 32'h0100_0203; #2;
      req("redir", 1'b1, T); out("redir", B + 28);
      nxt(); redirect = 1'b0; #2; empty("bubble"); req("bubble", 1'b1, T + 4);
      nxt(); #2; out("tgt0", T);
      nxt(); stall = 1'b1; #2; out("tgt1", T + 4);

      // Redirect while stalled with a full queue
      nxt(); #2; out("full", T + 4); req("full", 1'b0, T + 12);
      redirect = 1'b1; redirect_pc = R2; #1;
      req("redir_full", 1'b1, R2);
      nxt(); redirect = 1'b0; #2; empty("flush");
      nxt(); stall = 1'b0; #2; out("r2_0", R2);

      // PC wrap
      nxt(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; #2;
      out("r2_1", R2 + 4); req("wrap_req", 1'b1, 32'hFFFF_FFFC);
      nxt(); redirect = 1'b0; #2; empty("wrap_bub"); req("wrap_bub", 1'b1, 32'h0);
      nxt(); #2; out("wrap0", 32'hFFFF_FFFC);
      nxt(); #2; out("wrap1", 32'h0);

      // Asynchronous reset pulse between edges
      nxt(); #2; rst = 1'b0; #1;
      reset_vals("async");
      #1; rst = 1'b1; #1;
      req("restart", 1'b1, B); empty("restart");
      nxt(); #2; req("restart1", 1'b1, B + 4); empty("restart1");
      nxt(); #2; out("restart2", B);
      nxt(); #2; out("restart3", B + 4);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
